// File: rtl/nor_n_filter.sv
// nor_n_filter: registered, debounced WIDTH-input reduction gate.
// IN and MODE are captured every edge; the selected reduction (NOR/OR/NAND/AND)
// of the captured bus must disagree with QN for FILT consecutive enabled edges
// before QN/Q flip, and CHG pulses for exactly the cycle in which they flip.
`timescale 1ns/1ps

module nor_n_filter #(
  parameter int   WIDTH   = 3,
  parameter int   FILT    = 4,
  parameter logic RST_VAL = 1'b1
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] IN,
  output logic             QN,
  output logic             Q,
  output logic             CHG
);

  // Counter only has to reach FILT-1, so clog2(FILT+1) bits always suffice.
  localparam int CW = (FILT < 1) ? 1 : $clog2(FILT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

  typedef enum logic [1:0] {
    MODE_NOR  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_NAND = 2'b10,
    MODE_AND  = 2'b11
  } mode_e;

  // Reject illegal parameterisations at elaboration time.
  if (FILT < 1 || FILT > 255) begin : g_bad_filt
    $error("nor_n_filter: FILT must be in 1..255");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("nor_n_filter: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] in_q,   in_d;
  mode_e            mode_q, mode_d;
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic             qn_q,   qn_d;
  logic             q_q,    q_d;
  logic             chg_q,  chg_d;
  logic             raw;

  // Raw reduction of the registered inputs; never sees the unregistered bus.
  always_comb begin
    raw = 1'b0;
    unique case (mode_q)
      MODE_NOR:  raw = ~(|in_q);
      MODE_OR:   raw =   |in_q;
      MODE_NAND: raw = ~(&in_q);
      MODE_AND:  raw =   &in_q;
      default:   raw = 1'b0;
    endcase
  end

  // Next-state logic: input capture plus the stability filter.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch can be inferred.
    in_d   = IN;
    mode_d = mode_e'(MODE);
    cnt_d  = cnt_q;
    qn_d   = qn_q;
    q_d    = q_q;
    chg_d  = 1'b0;
    if (EN) begin
      if (raw == qn_q) begin
        // Agreement (including a bounce back) discards any partial count.
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        // Q is computed from raw, not from QN, so both outputs leave flops.
        qn_d  = raw;
        q_d   = ~raw;
        chg_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State register with synchronous active-low reset; reset overrides EN.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (!RSTB) begin
      in_q   <= '0;
      mode_q <= MODE_NOR;
      cnt_q  <= '0;
      qn_q   <= RST_VAL;
      q_q    <= ~RST_VAL;
      chg_q  <= 1'b0;
    end else begin
      in_q   <= in_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      qn_q   <= qn_d;
      q_q    <= q_d;
      chg_q  <= chg_d;
    end
  end

  assign QN  = qn_q;
  assign Q   = q_q;
  assign CHG = chg_q;

endmodule

// File: tb/tb_nor_n_filter.sv
// Testbench for nor_n_filter: two instances (FILT=4 and FILT=1) share the
// stimulus; each edge pushes the expected QN/CHG of the selected instance to a
// scoreboard queue that is popped and compared on the following falling edge.
`timescale 1ns/1ps

module tb_nor_n_filter;

  logic       clk = 1'b0;
  logic       rstb;
  logic       en;
  logic [1:0] mode;
  logic [2:0] in_bus;
  logic       qn4, q4, chg4;
  logic       qn1, q1, chg1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit    sel;   // 0: FILT=4 instance, 1: FILT=1 instance
    logic  qn;
    logic  chg;
    string tag;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  nor_n_filter #(.WIDTH(3), .FILT(4), .RST_VAL(1'b1)) dut4 (
    .CLK(clk), .RSTB(rstb), .EN(en), .MODE(mode), .IN(in_bus),
    .QN(qn4), .Q(q4), .CHG(chg4)
  );

  nor_n_filter #(.WIDTH(3), .FILT(1), .RST_VAL(1'b1)) dut1 (
    .CLK(clk), .RSTB(rstb), .EN(en), .MODE(mode), .IN(in_bus),
    .QN(qn1), .Q(q1), .CHG(chg1)
  );

  // Scoreboard consumer: one expectation per rising edge, checked mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic aqn, aq, achg;
    if (sb_q.size() != 0) begin
      e    = sb_q.pop_front();
      aqn  = e.sel ? qn1  : qn4;
      aq   = e.sel ? q1   : q4;
      achg = e.sel ? chg1 : chg4;
      checks++;
      if (aqn !== e.qn || aq !== ~e.qn || achg !== e.chg) begin
        errors++;
        $display("FAIL %s (dut FILT=%0d): QN/Q/CHG got %b/%b/%b, want %b/%b/%b",
                 e.tag, e.sel ? 1 : 4, aqn, aq, achg, e.qn, ~e.qn, e.chg);
      end
    end
  end

  // Apply inputs for one rising edge and record what that edge must produce.
  task automatic drive(input logic r, input logic e, input logic [1:0] m,
                       input logic [2:0] i, input bit sel,
                       input logic xqn, input logic xchg, input string tag);
    rstb   = r;
    en     = e;
    mode   = m;
    in_bus = i;
    sb_q.push_back('{sel, xqn, xchg, tag});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit sel);
    drive(1'b0, 1'b1, 2'b00, 3'b000, sel, 1'b1, 1'b0, "reset");
    drive(1'b0, 1'b1, 2'b00, 3'b000, sel, 1'b1, 1'b0, "reset");
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 2'b01, 3'b101, 1'b0, 1'b1, 1'b0, "rst_edge0");
    checks++;
    if (qn4 !== 1'b1 || q4 !== 1'b0 || chg4 !== 1'b0) begin
      errors++;
      $display("FAIL rst_inline: QN/Q/CHG got %b/%b/%b, want 1/0/0", qn4, q4, chg4);
    end
    drive(1'b0, 1'b1, 2'b01, 3'b101, 1'b0, 1'b1, 1'b0, "rst_edge1");
    for (int n = 0; n < 3; n++)
      drive(1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0, "rst_release");
  endtask

  // Fall after exactly FILT edges; IN returns to 000 on the completing edge,
  // which must not affect that decision and then restarts a fresh count.
  task automatic test_latency();
    for (int n = 0; n < 4; n++)
      drive(1'b1, 1'b1, 2'b00, 3'b010, 1'b0, 1'b1, 1'b0, "lat_wait");
    drive(1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1, "lat_fall");
    for (int n = 0; n < 3; n++)
      drive(1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, "lat_back_wait");
    drive(1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1'b1, 1'b1, "lat_back_rise");
    drive(1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0, "lat_settle");
  endtask

  task automatic test_bounce();
    for (int n = 0; n < 2; n++)
      drive(1'b1, 1'b1, 2'b00, 3'b010, 1'b0, 1'b1, 1'b0, "bounce_glitch");
    for (int n = 0; n < 3; n++)
      drive(1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0, "bounce_back");
    for (int n = 0; n < 4; n++)
      drive(1'b1, 1'b1, 2'b00, 3'b001, 1'b0, 1'b1, 1'b0, "bounce_recount");
    drive(1'b1, 1'b1, 2'b00, 3'b001, 1'b0, 1'b0, 1'b1, "bounce_fall");
    drive(1'b1, 1'b1, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, "bounce_settle");
  endtask

  task automatic test_en_pause();
    do_reset(1'b0);
    for (int n = 0; n < 2; n++)
      drive(1'b1, 1'b1, 2'b00, 3'b100, 1'b0, 1'b1, 1'b0, "en_count");
    for (int n = 0; n < 3; n++)
      drive(1'b1, 1'b0, 2'b00, 3'b100, 1'b0, 1'b1, 1'b0, "en_frozen");
    for (int n = 0; n < 2; n++)
      drive(1'b1, 1'b1, 2'b00, 3'b100, 1'b0, 1'b1, 1'b0, "en_resume");
    drive(1'b1, 1'b1, 2'b00, 3'b100, 1'b0, 1'b0, 1'b1, "en_fall");
    drive(1'b1, 1'b1, 2'b00, 3'b100, 1'b0, 1'b0, 1'b0, "en_settle");
  endtask

  task automatic test_mode_sweep();
    do_reset(1'b1);
    drive(1'b1, 1'b1, 2'b11, 3'b111, 1'b1, 1'b1, 1'b0, "and_sample");
    drive(1'b1, 1'b1, 2'b11, 3'b111, 1'b1, 1'b1, 1'b0, "and_hold");
    drive(1'b1, 1'b1, 2'b10, 3'b111, 1'b1, 1'b1, 1'b0, "nand_sample");
    drive(1'b1, 1'b1, 2'b10, 3'b111, 1'b1, 1'b0, 1'b1, "nand_fall");
    checks++;
    if (qn1 !== 1'b0 || chg1 !== 1'b1) begin
      errors++;
      $display("FAIL nand_inline: QN/CHG got %b/%b, want 0/1", qn1, chg1);
    end
    drive(1'b1, 1'b1, 2'b10, 3'b111, 1'b1, 1'b0, 1'b0, "nand_hold");
    drive(1'b1, 1'b1, 2'b01, 3'b111, 1'b1, 1'b0, 1'b0, "or_sample");
    drive(1'b1, 1'b1, 2'b01, 3'b111, 1'b1, 1'b1, 1'b1, "or_rise");
    drive(1'b1, 1'b1, 2'b01, 3'b111, 1'b1, 1'b1, 1'b0, "or_hold");
    drive(1'b1, 1'b1, 2'b00, 3'b111, 1'b1, 1'b1, 1'b0, "nor_sample");
    drive(1'b1, 1'b1, 2'b00, 3'b111, 1'b1, 1'b0, 1'b1, "nor_fall");
    drive(1'b1, 1'b1, 2'b00, 3'b111, 1'b1, 1'b0, 1'b0, "nor_hold");
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int n = 0; n < 2; n++)
      drive(1'b1, 1'b1, 2'b00, 3'b011, 1'b0, 1'b1, 1'b0, "mid_count");
    drive(1'b0, 1'b1, 2'b00, 3'b011, 1'b0, 1'b1, 1'b0, "mid_reset");
    for (int n = 0; n < 4; n++)
      drive(1'b1, 1'b1, 2'b00, 3'b011, 1'b0, 1'b1, 1'b0, "mid_recount");
    drive(1'b1, 1'b1, 2'b00, 3'b011, 1'b0, 1'b0, 1'b1, "mid_fall");
    drive(1'b1, 1'b1, 2'b00, 3'b011, 1'b0, 1'b0, 1'b0, "mid_settle");
  endtask

  initial begin
    rstb   = 1'b0;
    en     = 1'b1;
    mode   = 2'b00;
    in_bus = 3'b000;
    test_reset();
    test_latency();
    test_bounce();
    test_en_pause();
    test_mode_sweep();
    test_reset_mid();
    // Let the monitor drain the scoreboard, bounded in cycles.
    for (int n = 0; n < 8 && sb_q.size() != 0; n++)
      @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
